// File: rtl/alu_issue_ctrl.sv
// Execute-stage controller that decodes one instruction per handshake and drives an external ALU.
// Holds the operands for a settle window, captures the result and returns it over valid/ready.
module alu_issue_ctrl #(
    parameter int XLEN     = 32,
    parameter int ALU_WAIT = 1
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [6:0]      opcode,
    input  logic [2:0]      funct3,
    input  logic [6:0]      funct7,
    input  logic [XLEN-1:0] rs1_val,
    input  logic [XLEN-1:0] rs2_val,
    input  logic [XLEN-1:0] imm,
    output logic [3:0]      alu_ctl,
    output logic [XLEN-1:0] alu_a,
    output logic [XLEN-1:0] alu_b,
    input  logic [XLEN-1:0] alu_result,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [XLEN-1:0] result,
    output logic            br_taken,
    output logic            illegal
);
    localparam int CW = (ALU_WAIT > 0) ? $clog2(ALU_WAIT + 1) : 1;

    localparam logic [3:0] CTL_AND = 4'd0;
    localparam logic [3:0] CTL_OR  = 4'd1;
    localparam logic [3:0] CTL_ADD = 4'd2;
    localparam logic [3:0] CTL_SUB = 4'd6;
    localparam logic [3:0] CTL_SLT = 4'd7;
    localparam logic [3:0] CTL_BAD = 4'd15;

    typedef enum logic [1:0] {S_IDLE, S_DRIVE, S_DONE} state_t;

    state_t          state_q, state_d;
    logic [CW-1:0]   cnt_q, cnt_d;
    logic [3:0]      ctl_q, ctl_d;
    logic [XLEN-1:0] a_q, a_d, b_q, b_d, res_q, res_d;
    logic            ill_op_q, ill_op_d, br_op_q, br_op_d, br_ne_q, br_ne_d;
    logic            taken_q, taken_d, illegal_q, illegal_d;

    logic [3:0] dec_ctl;
    logic       dec_imm, dec_ill, dec_br;

    always_comb begin
        dec_ctl = CTL_BAD;
        dec_imm = 1'b0;
        dec_ill = 1'b1;
        dec_br  = 1'b0;
        case (opcode)
            7'b0110011: begin
                dec_ill = 1'b0;
                case (funct3)
                    3'b000: begin
                        if (funct7 == 7'h00)      dec_ctl = CTL_ADD;
                        else if (funct7 == 7'h20) dec_ctl = CTL_SUB;
                        else                      dec_ill = 1'b1;
                    end
                    3'b111:  dec_ctl = CTL_AND;
                    3'b110:  dec_ctl = CTL_OR;
                    3'b010:  dec_ctl = CTL_SLT;
                    default: dec_ill = 1'b1;
                endcase
            end
            7'b0010011: begin
                dec_ill = 1'b0;
                dec_imm = 1'b1;
                case (funct3)
                    3'b000:  dec_ctl = CTL_ADD;
                    3'b111:  dec_ctl = CTL_AND;
                    3'b110:  dec_ctl = CTL_OR;
                    3'b010:  dec_ctl = CTL_SLT;
                    default: dec_ill = 1'b1;
                endcase
            end
            7'b0000011, 7'b0100011: begin
                dec_ill = 1'b0;
                dec_imm = 1'b1;
                dec_ctl = CTL_ADD;
            end
            7'b1100011: begin
                if (funct3 == 3'b000 || funct3 == 3'b001) begin
                    dec_ill = 1'b0;
                    dec_br  = 1'b1;
                    dec_ctl = CTL_SUB;
                end
            end
            default: ;
        endcase
        // Illegal ops still run a handshake; the ALU returns 0 for code 15 anyway.
        if (dec_ill) dec_ctl = CTL_BAD;
    end

    assign in_ready = (state_q == S_IDLE) && !reset;

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        ctl_d     = ctl_q;
        a_d       = a_q;
        b_d       = b_q;
        res_d     = res_q;
        ill_op_d  = ill_op_q;
        br_op_d   = br_op_q;
        br_ne_d   = br_ne_q;
        taken_d   = taken_q;
        illegal_d = illegal_q;
        case (state_q)
            S_IDLE: begin
                if (in_valid) begin
                    ctl_d    = dec_ctl;
                    a_d      = rs1_val;
                    b_d      = dec_imm ? imm : rs2_val;
                    ill_op_d = dec_ill;
                    br_op_d  = dec_br;
                    br_ne_d  = funct3[0];
                    cnt_d    = CW'(ALU_WAIT);
                    state_d  = S_DRIVE;
                end
            end
            S_DRIVE: begin
                if (cnt_q != '0) begin
                    cnt_d = cnt_q - CW'(1);
                end else begin
                    res_d     = ill_op_q ? '0 : alu_result;
                    taken_d   = br_op_q && !ill_op_q &&
                                (br_ne_q ? (alu_result != '0) : (alu_result == '0));
                    illegal_d = ill_op_q;
                    state_d   = S_DONE;
                end
            end
            S_DONE: begin
                if (out_ready) state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= S_IDLE;
            cnt_q     <= '0;
            ctl_q     <= '0;
            a_q       <= '0;
            b_q       <= '0;
            res_q     <= '0;
            ill_op_q  <= 1'b0;
            br_op_q   <= 1'b0;
            br_ne_q   <= 1'b0;
            taken_q   <= 1'b0;
            illegal_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            ctl_q     <= ctl_d;
            a_q       <= a_d;
            b_q       <= b_d;
            res_q     <= res_d;
            ill_op_q  <= ill_op_d;
            br_op_q   <= br_op_d;
            br_ne_q   <= br_ne_d;
            taken_q   <= taken_d;
            illegal_q <= illegal_d;
        end
    end

    assign alu_ctl   = ctl_q;
    assign alu_a     = a_q;
    assign alu_b     = b_q;
    assign out_valid = (state_q == S_DONE);
    assign result    = res_q;
    assign br_taken  = taken_q;
    assign illegal   = illegal_q;
endmodule
